project_primitive: RTL and testbench

Parametrised projection engine that replaces the fixed three-vertex projector. It takes a primitive of VERTS object-space vertices and one pre-combined model-view-projection matrix, and produces screen-space Q16.16 vertices for the rasteriser. It offers two cull modes: strict discard and outcode trivial-reject. A single time-multiplexed MAC and one shared reciprocal unit replace the per-stage multipliers and three dividers.

---
 rtl/project_primitive.sv | 247 ++++++++++++++++++++++++
 tb/tb_project_primitive.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/project_primitive.sv
// Projects a VERTS-vertex primitive through one MVP matrix to screen-space Q-format vertices.
// Optional PROJECT_INV_W_EN adds the inv_w output (per-vertex saturated 1/w).
module project_primitive #(
   parameter int COORD_WIDTH = 32,
   parameter int VERTS       = 3,
   parameter int FB_WIDTH    = 320,
   parameter int FB_HEIGHT   = 180,
   parameter logic [COORD_WIDTH-1:0] NEAR_Q = 32'h0000199A,
   parameter logic [COORD_WIDTH-1:0] FAR_Q  = 32'h00640000
) (
   input  logic                                      clk_in,
   input  logic                                      rst_in,
   input  logic                                      start,
   input  logic                                      cull_mode,
   input  logic [VERTS-1:0][2:0][COORD_WIDTH-1:0]    prim_verts,
   input  logic [3:0][3:0][COORD_WIDTH-1:0]          mvp_matrix,
   output logic [VERTS-1:0][2:0][COORD_WIDTH-1:0]    projected_verts,
   output logic [VERTS-1:0]                          outside_mask,
   output logic                                      valid,
   output logic                                      busy,
   output logic                                      done
`ifdef PROJECT_INV_W_EN
   ,
   output logic [VERTS-1:0][COORD_WIDTH-1:0]         inv_w
`endif
);

   // state    | meaning
   // IDLE     | waiting for start
   // LOAD     | select vertex i, arm MAC counter
   // MAC      | 16 products, row-major, gives clip vector
   // CLIP     | outcode, plane mask, cull branch
   // RECIP    | restoring division 2^(2*FBITS)/cw
   // SCALE    | ndc = clip*recip for x, y, z
   // VIEWPORT | map ndc to screen, store vertex
   // DONE     | one-cycle completion pulse

   localparam int CW    = COORD_WIDTH;
   localparam int FBITS = CW / 2;
   localparam int DW    = CW + FBITS;
   localparam int PW    = 2 * CW;
   localparam int AW    = 2 * CW + 2;
   localparam int VI_W  = (VERTS > 1) ? $clog2(VERTS) : 1;
   localparam int CNT_W = $clog2(DW) + 1;

   localparam logic signed [CW-1:0] ONE      = {{(CW-FBITS-1){1'b0}}, 1'b1, {FBITS{1'b0}}};
   localparam logic [CW-1:0]        MAXPOS   = {1'b0, {(CW-1){1'b1}}};
   localparam logic [DW-1:0]        DVD_INIT = DW'(1) << (2 * FBITS);
   localparam logic signed [PW-1:0] ONE_W    = {{(PW-CW){1'b0}}, ONE};
   localparam logic signed [PW-1:0] HALF_W_W = PW'(FB_WIDTH / 2);
   localparam logic signed [PW-1:0] HALF_H_W = PW'(FB_HEIGHT / 2);
   localparam logic [CW-1:0]        ZDIFF    = FAR_Q - NEAR_Q;
   localparam logic [CW:0]          ZSUM     = {1'b0, FAR_Q} + {1'b0, NEAR_Q};
   localparam logic signed [PW-1:0] ZH_W     = {{(PW-CW+1){1'b0}}, ZDIFF[CW-1:1]};
   localparam logic [CW-1:0]        ZC       = ZSUM[CW:1];
   localparam logic [VI_W-1:0]      VI_LAST  = VI_W'(VERTS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_MAC, S_CLIP, S_RECIP, S_SCALE, S_VIEWPORT, S_DONE
   } state_t;

   state_t state, state_nx;

   logic [VERTS-1:0][2:0][CW-1:0] prim_r;
   logic [3:0][3:0][CW-1:0]       mvp_r;
   logic                          mode_r;
   logic [VI_W-1:0]               vi;
   logic [CNT_W-1:0]              cnt;
   logic signed [AW-1:0]          acc;
   logic [3:0][CW-1:0]            clip;
   logic [2:0][CW-1:0]            ndc;
   logic [5:0]                    plane;
   logic [CW-1:0]                 rem;
   logic [DW-1:0]                 quo;
   logic [DW-1:0]                 dvd;

   logic [3:0]            idx;
   logic [1:0]            row, col;
   logic [CW-1:0]         vec_elem;
   logic [CW-1:0]         clip_sel;
   logic [CW-1:0]         mul_a, mul_b;
   logic signed [PW-1:0]  mul_a_w, mul_b_w, prod;
   logic signed [AW-1:0]  acc_sum;
   logic signed [CW:0]    cx_e, cy_e, cz_e, cw_e, ncw_e;
   logic [5:0]            oc;
   logic                  cull;
   logic [CW:0]           trial;
   logic                  ge;
   logic [CW-1:0]         recip_sat;
   logic signed [PW-1:0]  ndcx_w, ndcy_w, ndcz_w;
   logic [CW-1:0]         vx, vy, vz;

   // MAC walks the matrix row-major while the counter runs 15 down to 0
   assign idx = ~cnt[3:0];
   assign row = idx[3:2];
   assign col = idx[1:0];

   always_comb begin
      vec_elem = ONE;
      case (col)
         2'd0: vec_elem = prim_r[vi][0];
         2'd1: vec_elem = prim_r[vi][1];
         2'd2: vec_elem = prim_r[vi][2];
         default: vec_elem = ONE;
      endcase
   end

   always_comb begin
      clip_sel = clip[2];
      case (cnt[1:0])
         2'd2: clip_sel = clip[0];
         2'd1: clip_sel = clip[1];
         default: clip_sel = clip[2];
      endcase
   end

   assign recip_sat = (quo > DW'(MAXPOS)) ? MAXPOS : quo[CW-1:0];

   // single shared multiplier: matrix products in MAC, clip*recip in SCALE
   assign mul_a   = (state == S_SCALE) ? clip_sel  : mvp_r[row][col];
   assign mul_b   = (state == S_SCALE) ? recip_sat : vec_elem;
   assign mul_a_w = {{(PW-CW){mul_a[CW-1]}}, mul_a};
   assign mul_b_w = {{(PW-CW){mul_b[CW-1]}}, mul_b};
   assign prod    = mul_a_w * mul_b_w;
   assign acc_sum = ((col == 2'd0) ? '0 : acc) + {{(AW-PW){prod[PW-1]}}, prod};

   assign cx_e  = {clip[0][CW-1], clip[0]};
   assign cy_e  = {clip[1][CW-1], clip[1]};
   assign cz_e  = {clip[2][CW-1], clip[2]};
   assign cw_e  = {clip[3][CW-1], clip[3]};
   assign ncw_e = -cw_e;
   assign oc    = {cz_e < ncw_e, cz_e > cw_e, cy_e < ncw_e, cy_e > cw_e,
                   cx_e < ncw_e, cx_e > cw_e};
   assign cull  = (cw_e <= 0) || (!mode_r && (oc != 6'd0));

   assign trial = {rem, dvd[DW-1]};
   assign ge    = trial >= {1'b0, clip[3]};

   assign ndcx_w = {{(PW-CW){ndc[0][CW-1]}}, ndc[0]};
   assign ndcy_w = {{(PW-CW){ndc[1][CW-1]}}, ndc[1]};
   assign ndcz_w = {{(PW-CW){ndc[2][CW-1]}}, ndc[2]};
   assign vx     = CW'(HALF_W_W * (ndcx_w + ONE_W));
   assign vy     = CW'(HALF_H_W * (ONE_W - ndcy_w));
   assign vz     = CW'((ZH_W * ndcz_w) >>> FBITS) + ZC;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:     if (start) state_nx = S_LOAD;
         S_LOAD:     state_nx = S_MAC;
         S_MAC:      if (cnt == '0) state_nx = S_CLIP;
         S_CLIP:     state_nx = cull ? S_DONE : S_RECIP;
         S_RECIP:    if (cnt == '0) state_nx = S_SCALE;
         S_SCALE:    if (cnt == '0) state_nx = S_VIEWPORT;
         S_VIEWPORT: state_nx = (vi == VI_LAST) ? S_DONE : S_LOAD;
         S_DONE:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      if (state != S_IDLE) busy = 1'b1;
      if (state == S_DONE) done = 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         prim_r          <= '0;
         mvp_r           <= '0;
         mode_r          <= 1'b0;
         vi              <= '0;
         cnt             <= '0;
         acc             <= '0;
         clip            <= '0;
         ndc             <= '0;
         plane           <= '0;
         rem             <= '0;
         quo             <= '0;
         dvd             <= '0;
         projected_verts <= '0;
         outside_mask    <= '0;
         valid           <= 1'b0;
`ifdef PROJECT_INV_W_EN
         inv_w           <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: if (start) begin
               prim_r          <= prim_verts;
               mvp_r           <= mvp_matrix;
               mode_r          <= cull_mode;
               outside_mask    <= '0;
               projected_verts <= '0;
               valid           <= 1'b0;
               plane           <= 6'h3F;
               vi              <= '0;
`ifdef PROJECT_INV_W_EN
               inv_w           <= '0;
`endif
            end
            S_LOAD: cnt <= CNT_W'(15);
            S_MAC: begin
               acc <= acc_sum;
               if (col == 2'd3) clip[row] <= CW'(acc_sum >>> FBITS);
               cnt <= cnt - CNT_W'(1);
            end
            S_CLIP: begin
               plane            <= plane & oc;
               outside_mask[vi] <= (oc != 6'd0);
               rem              <= '0;
               quo              <= '0;
               dvd              <= DVD_INIT;
               cnt              <= CNT_W'(DW - 1);
            end
            S_RECIP: begin
               rem <= ge ? CW'(trial - {1'b0, clip[3]}) : CW'(trial);
               quo <= {quo[DW-2:0], ge};
               dvd <= dvd << 1;
               cnt <= (cnt == '0) ? CNT_W'(2) : cnt - CNT_W'(1);
            end
            S_SCALE: begin
               ndc[2'd2 - cnt[1:0]] <= CW'(prod >>> FBITS);
               cnt <= cnt - CNT_W'(1);
            end
            S_VIEWPORT: begin
               projected_verts[vi][0] <= vx;
               projected_verts[vi][1] <= vy;
               projected_verts[vi][2] <= vz;
`ifdef PROJECT_INV_W_EN
               inv_w[vi]              <= recip_sat;
`endif
               if (vi == VI_LAST) valid <= mode_r ? (plane == 6'd0) : 1'b1;
               else               vi    <= vi + VI_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_project_primitive.sv
// Self-checking bench for project_primitive: directed cases plus randomized primitives
// compared against an arithmetic projection model.
module tb_project_primitive;

   localparam int  CW    = 32;
   localparam int  VERTS = 3;
   localparam int  P     = 70;
   localparam longint FAR_L  = 64'h0000_0000_0064_0000;
   localparam longint NEAR_L = 64'h0000_0000_0000_199A;
   localparam longint ONE_L  = 65536;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic cull_mode = 1'b0;
   logic [VERTS-1:0][2:0][CW-1:0] prim_verts = '0;
   logic [3:0][3:0][CW-1:0]       mvp_matrix = '0;
   logic [VERTS-1:0][2:0][CW-1:0] projected_verts;
   logic [VERTS-1:0]              outside_mask;
   logic valid, busy, done;

   project_primitive dut (
      .clk_in(clk), .rst_in(rst), .start(start), .cull_mode(cull_mode),
      .prim_verts(prim_verts), .mvp_matrix(mvp_matrix),
      .projected_verts(projected_verts), .outside_mask(outside_mask),
      .valid(valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [VERTS-1:0][2:0][31:0] m_pv;
   logic [3:0][3:0][31:0]       m_mx;
   bit                          m_mode;
   logic [VERTS-1:0][2:0][31:0] e_proj;
   logic [VERTS-1:0]            e_mask;
   logic                        e_valid;
   int                          e_cyc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rnd(input int lo, input int hi);
      return lo + int'($urandom_range(0, hi - lo));
   endfunction

   // projection straight from the formulas: clip = M*v, 1/w, ndc, viewport
   task automatic model();
      longint v[4];
      longint cl[4];
      longint nd[3];
      longint s, q, cw;
      logic [5:0] plane, oc;
      int exitv;
      e_proj = '0;
      e_mask = '0;
      plane  = 6'h3F;
      exitv  = -1;
      for (int i = 0; i < VERTS; i++) begin
         for (int c = 0; c < 3; c++) v[c] = longint'($signed(m_pv[i][c]));
         v[3] = ONE_L;
         for (int r = 0; r < 4; r++) begin
            s = 0;
            for (int c = 0; c < 4; c++) s += longint'($signed(m_mx[r][c])) * v[c];
            cl[r] = longint'(int'(s >>> 16));
         end
         cw = cl[3];
         oc = {cl[2] < -cw, cl[2] > cw, cl[1] < -cw, cl[1] > cw, cl[0] < -cw, cl[0] > cw};
         plane = plane & oc;
         e_mask[i] = (oc != 0);
         if (cw <= 0 || (!m_mode && oc != 0)) begin
            exitv = i;
            break;
         end
         q = (longint'(1) <<< 32) / cw;
         if (q > 2147483647) q = 2147483647;
         for (int k = 0; k < 3; k++) nd[k] = longint'(int'((cl[k] * q) >>> 16));
         e_proj[i][0] = 32'((320 / 2) * (nd[0] + ONE_L));
         e_proj[i][1] = 32'((180 / 2) * (ONE_L - nd[1]));
         e_proj[i][2] = 32'(((((FAR_L - NEAR_L) / 2) * nd[2]) >>> 16) + (FAR_L + NEAR_L) / 2);
      end
      e_valid = (exitv >= 0) ? 1'b0 : (m_mode ? (plane == 0) : 1'b1);
      e_cyc   = (exitv >= 0) ? exitv * P + 19 : VERTS * P + 1;
   endtask

   task automatic set_identity();
      m_mx = '0;
      for (int r = 0; r < 4; r++) m_mx[r][r] = 32'h0001_0000;
   endtask

   task automatic scramble_inputs();
      for (int i = 0; i < VERTS; i++)
         for (int c = 0; c < 3; c++) prim_verts[i][c] = $urandom;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) mvp_matrix[r][c] = $urandom;
   endtask

   task automatic run(input bit mode, input string name);
      int cyc;
      bit got;
      m_mode = mode;
      model();
      @(negedge clk);
      prim_verts = m_pv;
      mvp_matrix = m_mx;
      cull_mode  = mode;
      start      = 1'b1;
      @(posedge clk);
      cyc = 1;
      got = 1'b0;
      @(negedge clk);
      start     = 1'b0;
      cull_mode = ~mode;
      scramble_inputs();
      check({name, ":busy_after_start"}, {busy, done}, 2'b10);
      for (int k = 0; k < 1000; k++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
         start = (cyc == 6);
      end
      start = 1'b0;
      check({name, ":done_seen"}, got, 1'b1);
      check({name, ":done_cycle"}, cyc, e_cyc);
      check({name, ":valid"}, valid, e_valid);
      check({name, ":outside_mask"}, outside_mask, e_mask);
      for (int i = 0; i < VERTS; i++)
         for (int c = 0; c < 3; c++)
            check($sformatf("%s:v%0d.%0d", name, i, c), projected_verts[i][c], e_proj[i][c]);
      @(posedge clk);
      @(negedge clk);
      check({name, ":idle_after_done"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int cyc;
      bit saw_done;

      repeat (3) @(negedge clk);
      check("reset:outputs", {valid, busy, done, outside_mask}, '0);
      check("reset:proj", projected_verts, '0);
      rst = 1'b0;

      // all vertices inside, known screen result
      set_identity();
      for (int i = 0; i < VERTS; i++) m_pv[i] = {32'h0000_8000, 32'h0, 32'h0};
      run(1'b0, "t1_inside");
      check("t1:const_x", projected_verts[2][0], 32'h00A0_0000);
      check("t1:const_y", projected_verts[2][1], 32'h005A_0000);
      check("t1:const_z", projected_verts[2][2], 32'h004B_0666);

      // strict discard on the first vertex
      m_pv[0][0] = 32'h0002_0000;
      run(1'b0, "t2_strict");
      check("t2:mask_const", outside_mask, 3'b001);

      // trivial-reject passes when outside vertices straddle different planes
      for (int i = 0; i < VERTS; i++) m_pv[i] = {32'h0000_8000, 32'h0, 32'h0};
      m_pv[0][0] = 32'hFFFE_0000;
      m_pv[2][0] = 32'h0002_0000;
      run(1'b1, "t3_straddle");
      check("t3:valid_const", valid, 1'b1);
      check("t3:v1x_const", projected_verts[1][0], 32'h00A0_0000);

      // all on the same side of x>w: rejected after full traversal
      for (int i = 0; i < VERTS; i++) m_pv[i][0] = 32'h0002_0000;
      run(1'b1, "t4_reject");
      check("t4:valid_const", valid, 1'b0);

      // w row zero -> cw = 0 exits on vertex 0
      for (int c = 0; c < 4; c++) m_mx[3][c] = '0;
      run(1'b1, "t5_w_zero");

      // asynchronous reset mid-run
      set_identity();
      for (int i = 0; i < VERTS; i++) m_pv[i] = {32'h0000_8000, 32'h0, 32'h0};
      @(negedge clk);
      prim_verts = m_pv;
      mvp_matrix = m_mx;
      cull_mode  = 1'b0;
      start      = 1'b1;
      @(posedge clk);
      cyc = 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check("t6:pre_reset_v0x", projected_verts[0][0], 32'h00A0_0000);
      rst = 1'b1;
      #1;
      check("t6:reset_ctrl", {valid, busy, done, outside_mask}, '0);
      check("t6:reset_proj", projected_verts, '0);
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("t6:no_done_pulse", saw_done, 1'b0);
      run(1'b0, "t6_after_reset");

      // randomized primitives around the identity
      for (int t = 0; t < 12; t++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               m_mx[r][c] = 32'(((r == c) ? 65536 : 0) + rnd(-24576, 24576));
         for (int i = 0; i < VERTS; i++)
            for (int c = 0; c < 3; c++)
               m_pv[i][c] = 32'(rnd(-98304, 98304));
         run(bit'($urandom_range(0, 1)), $sformatf("rand%0d", t));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
